// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit ALU: accepts one command, drives and holds the ALU
// inputs, captures the result into the accumulator and flags, then returns a response.
module alu_issue_ctrl #(
  parameter int unsigned MULDIV_WAIT = 3  // extra ISSUE cycles for MUL/DIV, 0..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_operand,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_sub,
  output logic [2:0] alu_op_select,
  input  logic [7:0] alu_result,
  input  logic       alu_cout,
  input  logic       alu_overflow,
  output logic [7:0] acc,
  output logic [3:0] flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  typedef struct packed {
    logic c;
    logic v;
    logic n;
    logic z;
  } flags_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_LDA = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  localparam logic [3:0] MULDIV_CNT = 4'(MULDIV_WAIT);

  state_e     state_q;
  logic [7:0] acc_q;
  logic [7:0] alu_b_q;
  logic [2:0] alu_op_q;
  logic       alu_sub_q;
  logic [3:0] cnt_q;
  flags_t     flags_q;
  logic       err_q;
  logic       arith_op;

  // Carry and overflow are only meaningful for the adder path.
  assign arith_op = (alu_op_q == OP_ADD) || (alu_op_q == OP_SUB);

  // NOTE: every register here is updated with <= so each branch sees pre-edge values;
  // the asynchronous reset clears all of them, which is what aborts an in-flight op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acc_q     <= 8'h00;
      alu_b_q   <= 8'h00;
      alu_op_q  <= 3'b000;
      alu_sub_q <= 1'b0;
      cnt_q     <= 4'd0;
      flags_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_op == OP_LDA) begin
              acc_q   <= cmd_operand;
              flags_q <= '{c: 1'b0, v: 1'b0, n: cmd_operand[7], z: (cmd_operand == 8'h00)};
              err_q   <= 1'b0;
              state_q <= ST_RESP;
            end else if ((cmd_op == OP_RSV) || ((cmd_op == OP_DIV) && (cmd_operand == 8'h00))) begin
              err_q   <= 1'b1;
              state_q <= ST_RESP;
            end else begin
              alu_b_q   <= cmd_operand;
              alu_op_q  <= cmd_op;
              alu_sub_q <= (cmd_op == OP_SUB);
              cnt_q     <= ((cmd_op == OP_MUL) || (cmd_op == OP_DIV)) ? MULDIV_CNT : 4'd0;
              err_q     <= 1'b0;
              state_q   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            acc_q   <= alu_result;
            flags_q <= '{c: arith_op & alu_cout,
                         v: arith_op & alu_overflow,
                         n: alu_result[7],
                         z: (alu_result == 8'h00)};
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state_q == ST_IDLE) && rst_n;
  assign busy          = (state_q != ST_IDLE);
  assign rsp_valid     = (state_q == ST_RESP);
  assign rsp_data      = acc_q;
  assign rsp_err       = err_q;
  assign acc           = acc_q;
  assign flags         = flags_q;
  assign alu_a         = acc_q;
  assign alu_b         = alu_b_q;
  assign alu_sub       = alu_sub_q;
  assign alu_op_select = alu_op_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: a behavioural ALU closes the loop, and each
// scenario task compares DUT outputs against hand-computed values.
module tb_alu_issue_ctrl;

  localparam int MW = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [7:0] cmd_operand = 8'h00;
  logic [7:0] alu_a, alu_b;
  logic       alu_sub;
  logic [2:0] alu_op_select;
  logic [7:0] alu_result;
  logic       alu_cout, alu_overflow;
  logic [7:0] acc;
  logic [3:0] flags;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  int checks = 0;
  int failures = 0;
  logic glitch_en = 1'b0;

  alu_issue_ctrl #(.MULDIV_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_operand(cmd_operand),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sub(alu_sub), .alu_op_select(alu_op_select),
    .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
    .acc(acc), .flags(flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; glitch_en corrupts the result to prove it is only sampled late.
  logic [7:0]  m_be, m_res;
  logic [8:0]  m_sum;
  logic [15:0] m_prod;
  logic        m_c, m_v;
  always_comb begin
    m_be   = alu_sub ? ~alu_b : alu_b;
    m_sum  = {1'b0, alu_a} + {1'b0, m_be} + {8'h00, alu_sub};
    m_prod = {8'h00, alu_a} * {8'h00, alu_b};
    m_res  = 8'h00;
    m_c    = 1'b0;
    m_v    = 1'b0;
    case (alu_op_select)
      3'b000, 3'b001: begin
        m_res = m_sum[7:0];
        m_c   = m_sum[8];
        m_v   = (alu_a[7] == m_be[7]) && (m_sum[7] != alu_a[7]);
      end
      3'b010: m_res = alu_a & alu_b;
      3'b011: m_res = alu_a | alu_b;
      3'b100: m_res = m_prod[7:0];
      3'b101: m_res = (alu_b == 8'h00) ? 8'hFF : (alu_a / alu_b);
      default: m_res = 8'h00;
    endcase
  end
  assign alu_result   = glitch_en ? 8'hEE : m_res;
  assign alu_cout     = m_c;
  assign alu_overflow = m_v;

  // Waits for cmd_ready, presents one command for one edge, then counts edges until rsp_valid.
  task automatic send(input logic [2:0] op, input logic [7:0] opd, output int lat);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    cmd_op = op; cmd_operand = opd; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({acc, flags, alu_b, alu_op_select, alu_sub, rsp_valid, rsp_err, busy} !== 27'd0) begin
      failures++;
      $display("FAIL reset_state got acc=%h flags=%b b=%h sel=%b sub=%b rv=%b err=%b busy=%b exp all zero",
               acc, flags, alu_b, alu_op_select, alu_sub, rsp_valid, rsp_err, busy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    send(3'b110, 8'h05, lat);
    checks++;
    if (lat !== 0 || rsp_data !== 8'h05) begin
      failures++; $display("FAIL lda_latency got lat=%0d data=%h exp lat=0 data=05", lat, rsp_data);
    end
    consume();
    send(3'b000, 8'h03, lat);
    checks++;
    if (lat !== 1) begin
      failures++; $display("FAIL add_latency got=%0d exp=1", lat);
    end
    checks++;
    if ({rsp_data, flags, rsp_err} !== {8'h08, 4'b0000, 1'b0}) begin
      failures++; $display("FAIL add_result got data=%h flags=%b err=%b exp data=08 flags=0000 err=0",
                           rsp_data, flags, rsp_err);
    end
    consume();
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL add_return_idle got ready=%b busy=%b exp ready=1 busy=0", cmd_ready, busy);
    end
  endtask

  task automatic test_overflow_sub();
    int lat;
    send(3'b110, 8'h7F, lat); consume();
    send(3'b000, 8'h01, lat);
    checks++;
    if ({rsp_data, flags} !== {8'h80, 4'b0110}) begin
      failures++; $display("FAIL add_overflow got data=%h flags=%b exp data=80 flags=0110", rsp_data, flags);
    end
    consume();
    send(3'b110, 8'h05, lat); consume();
    cmd_op = 3'b001; cmd_operand = 8'h05; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if ({alu_sub, alu_op_select, alu_b, rsp_valid, busy} !== {1'b1, 3'b001, 8'h05, 1'b0, 1'b1}) begin
      failures++; $display("FAIL sub_issue got sub=%b sel=%b b=%h rv=%b busy=%b exp sub=1 sel=001 b=05 rv=0 busy=1",
                           alu_sub, alu_op_select, alu_b, rsp_valid, busy);
    end
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_data, flags} !== {1'b1, 8'h00, 4'b1001}) begin
      failures++; $display("FAIL sub_zero got rv=%b data=%h flags=%b exp rv=1 data=00 flags=1001",
                           rsp_valid, rsp_data, flags);
    end
    consume();
  endtask

  task automatic test_logic();
    int lat;
    send(3'b110, 8'hAA, lat); consume();
    send(3'b010, 8'h0F, lat);
    checks++;
    if ({lat[3:0], rsp_data, flags} !== {4'd1, 8'h0A, 4'b0000}) begin
      failures++; $display("FAIL and_result got lat=%0d data=%h flags=%b exp lat=1 data=0a flags=0000",
                           lat, rsp_data, flags);
    end
    consume();
    send(3'b011, 8'hF0, lat);
    checks++;
    if ({rsp_data, flags} !== {8'hFA, 4'b0010}) begin
      failures++; $display("FAIL or_result got data=%h flags=%b exp data=fa flags=0010", rsp_data, flags);
    end
    consume();
  endtask

  task automatic test_reserved_hold();
    int lat;
    int bad;
    send(3'b111, 8'h33, lat);
    checks++;
    if ({lat[3:0], rsp_err, rsp_data, flags} !== {4'd0, 1'b1, 8'hFA, 4'b0010}) begin
      failures++; $display("FAIL rsv_err got lat=%0d err=%b data=%h flags=%b exp lat=0 err=1 data=fa flags=0010",
                           lat, rsp_err, rsp_data, flags);
    end
    bad = 0;
    cmd_op = 3'b110; cmd_operand = 8'h11;
    for (int i = 0; i < 5; i++) begin
      cmd_valid = i[0];
      @(posedge clk); #1;
      if ({rsp_valid, rsp_data, rsp_err, cmd_ready} !== {1'b1, 8'hFA, 1'b1, 1'b0}) bad++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL rsv_hold got unstable_cycles=%0d exp 0", bad);
    end
    consume();
    checks++;
    if ({acc, flags, cmd_ready} !== {8'hFA, 4'b0010, 1'b1}) begin
      failures++; $display("FAIL rsv_unchanged got acc=%h flags=%b ready=%b exp acc=fa flags=0010 ready=1",
                           acc, flags, cmd_ready);
    end
  endtask

  task automatic test_muldiv();
    int lat;
    int bad;
    send(3'b110, 8'h0C, lat); consume();
    cmd_op = 3'b100; cmd_operand = 8'h03; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    bad = 0;
    for (int i = 0; i <= MW; i++) begin
      if ({alu_a, alu_b, alu_op_select, alu_sub, rsp_valid} !== {8'h0C, 8'h03, 3'b100, 1'b0, 1'b0}) bad++;
      glitch_en = (i < MW);
      @(posedge clk); #1;
    end
    glitch_en = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL mul_hold got unstable_cycles=%0d exp 0", bad);
    end
    checks++;
    if ({rsp_valid, rsp_data, flags} !== {1'b1, 8'h24, 4'b0000}) begin
      failures++; $display("FAIL mul_result got rv=%b data=%h flags=%b exp rv=1 data=24 flags=0000",
                           rsp_valid, rsp_data, flags);
    end
    consume();
    send(3'b101, 8'h00, lat);
    checks++;
    if ({lat[3:0], rsp_err, rsp_data, acc} !== {4'd0, 1'b1, 8'h24, 8'h24}) begin
      failures++; $display("FAIL div0_err got lat=%0d err=%b data=%h acc=%h exp lat=0 err=1 data=24 acc=24",
                           lat, rsp_err, rsp_data, acc);
    end
    consume();
  endtask

  task automatic test_reset_abort();
    int lat;
    logic seen;
    send(3'b110, 8'h0C, lat); consume();
    cmd_op = 3'b100; cmd_operand = 8'h05; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({acc, flags, alu_a, alu_b, alu_op_select, alu_sub, rsp_valid, busy} !== 34'd0) begin
      failures++; $display("FAIL abort_clear got acc=%h flags=%b a=%h b=%h sel=%b sub=%b rv=%b busy=%b exp all zero",
                           acc, flags, alu_a, alu_b, alu_op_select, alu_sub, rsp_valid, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL abort_no_rsp got rsp_seen=%b exp 0", seen);
    end
    send(3'b000, 8'h01, lat);
    checks++;
    if ({lat[3:0], rsp_data, flags} !== {4'd1, 8'h01, 4'b0000}) begin
      failures++; $display("FAIL abort_recover got lat=%0d data=%h flags=%b exp lat=1 data=01 flags=0000",
                           lat, rsp_data, flags);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    rsp_ready = 1'b1;
    cmd_op = 3'b000; cmd_operand = 8'h01; cmd_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (cmd_ready) n++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    checks++;
    if (n !== 3 || acc !== 8'h04) begin
      failures++; $display("FAIL b2b_rate got accepts=%0d acc=%h exp accepts=3 acc=04", n, acc);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow_sub();
    test_logic();
    test_reserved_hold();
    test_muldiv();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
